// File: rtl/boxcar_pkg.sv
// Shared widths, legal parameter ranges and helper functions for the
// boxcar decimator. Optional build macro used by the top: BOXCAR_ROUND_EN.
package boxcar_pkg;

   // Legal parameter ranges
   localparam int unsigned LOG2_WINDOW_MIN = 1;
   localparam int unsigned LOG2_WINDOW_MAX = 12;
   localparam int unsigned DECIM_MIN       = 1;
   localparam int unsigned DECIM_MAX       = 65535;

   // Accumulator width: a full window of full-scale samples never overflows
   function automatic int unsigned ACC_W(input int unsigned data_w,
                                         input int unsigned log2_window);
      return data_w + log2_window;
   endfunction

   // Decimation counter width: wide enough to hold DECIM itself
   function automatic int unsigned DCNT_W(input int unsigned decim);
      return $clog2(decim + 1);
   endfunction

   // Elaboration-time range check used by the top-level parameter guard
   function automatic bit boxcar_params_legal(input int unsigned log2_window,
                                              input int unsigned decim);
      return (log2_window >= LOG2_WINDOW_MIN) && (log2_window <= LOG2_WINDOW_MAX) &&
             (decim >= DECIM_MIN) && (decim <= DECIM_MAX);
   endfunction

endpackage : boxcar_pkg

// File: rtl/boxcar_ring_ram.sv
// Simple dual-port ring buffer RAM. Registered read; a read and write to the
// same address in one cycle returns the previously stored word. No reset.
module boxcar_ring_ram
   import boxcar_pkg::*;
#(
   parameter int unsigned DATA_W = 14,
   parameter int unsigned ADDR_W = 8
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   // Write port and registered read port; non-blocking read yields old data
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule : boxcar_ring_ram

// File: rtl/boxcar_decimator.sv
// Boxcar (moving-average) filter with integrated decimation.
// Running sum over a 2**LOG2_WINDOW ring buffer; one mean per DECIM accepted
// samples, flagged by a one-cycle TRIGGER three cycles after the accept.
// Build macro BOXCAR_ROUND_EN: round half up instead of truncating the mean.
module boxcar_decimator
   import boxcar_pkg::*;
#(
   parameter int unsigned DATA_W      = 14,
   parameter int unsigned LOG2_WINDOW = 8,
   parameter int unsigned DECIM       = 325
) (
   input  logic              CLOCK_IN,
   input  logic              RESET_IN,
   input  logic              ENABLE,
   input  logic [DATA_W-1:0] DATA_IN,
   output logic [DATA_W-1:0] DATA_OUT,
   output logic              TRIGGER,
   output logic              FILLED
);

   localparam int unsigned N         = 1 << LOG2_WINDOW;
   localparam int unsigned ACC_BITS  = ACC_W(DATA_W, LOG2_WINDOW);
   localparam int unsigned DCNT_BITS = DCNT_W(DECIM);
   localparam int unsigned FILL_W    = LOG2_WINDOW + 1;

   localparam logic [FILL_W-1:0]    FILL_FULL  = FILL_W'(N);
   localparam logic [FILL_W-1:0]    FILL_LAST  = FILL_W'(N - 1);
   localparam logic [DCNT_BITS-1:0] DCNT_LAST  = DCNT_BITS'(DECIM - 1);
`ifdef BOXCAR_ROUND_EN
   localparam logic [ACC_BITS-1:0]  ROUND_HALF = ACC_BITS'(1) << (LOG2_WINDOW - 1);
`endif

   // Parameter range guard
   if (!boxcar_params_legal(LOG2_WINDOW, DECIM)) begin : g_bad_params
      $fatal(1, "boxcar_decimator: LOG2_WINDOW or DECIM out of range");
   end

   // Control state
   logic [LOG2_WINDOW-1:0] wr_ptr_q,   wr_ptr_d;
   logic [FILL_W-1:0]      fill_cnt_q, fill_cnt_d;
   logic                   filled_q,   filled_d;
   logic [DCNT_BITS-1:0]   dcnt_q,     dcnt_d;

   // Stage 1: accepted sample and its flags (old sample arrives from RAM)
   logic                   s1_vld_q,   s1_vld_d;
   logic [DATA_W-1:0]      s1_x_q,     s1_x_d;
   logic                   s1_stale_q, s1_stale_d;
   logic                   s1_qual_q,  s1_qual_d;

   // Stage 2: signed difference new - evicted
   logic                   s2_vld_q,   s2_vld_d;
   logic signed [DATA_W:0] s2_diff_q,  s2_diff_d;
   logic                   s2_qual_q,  s2_qual_d;

   // Stage 3/4: running sum and output registers
   logic [ACC_BITS-1:0]    acc_q,      acc_d;
   logic [DATA_W-1:0]      data_out_q, data_out_d;
   logic                   trigger_q,  trigger_d;

   // Combinational helpers
   logic                     accept;
   logic                     dcnt_wrap;
   logic [DATA_W-1:0]        ram_rdata;
   logic [DATA_W-1:0]        old_sample;
   logic signed [ACC_BITS:0] diff_ext;
   logic signed [ACC_BITS:0] acc_sum;
   logic [ACC_BITS-1:0]      acc_rnd;

   assign accept = ENABLE & ~RESET_IN;

   // Ring buffer: read the slot about to be overwritten, write the new sample
   boxcar_ring_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (LOG2_WINDOW)
   ) u_ring_ram (
      .clk_i   (CLOCK_IN),
      .we_i    (accept),
      .waddr_i (wr_ptr_q),
      .wdata_i (DATA_IN),
      .re_i    (accept),
      .raddr_i (wr_ptr_q),
      .rdata_o (ram_rdata)
   );

   // Next-state logic for pointers, counters and all pipeline stages
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      fill_cnt_d = fill_cnt_q;
      filled_d   = filled_q;
      dcnt_d     = dcnt_q;
      s1_vld_d   = 1'b0;
      s1_x_d     = s1_x_q;
      s1_stale_d = s1_stale_q;
      s1_qual_d  = s1_qual_q;
      s2_vld_d   = s1_vld_q;
      s2_diff_d  = s2_diff_q;
      s2_qual_d  = s2_qual_q;
      acc_d      = acc_q;
      data_out_d = data_out_q;
      trigger_d  = 1'b0;
      dcnt_wrap  = (dcnt_q == DCNT_LAST);
      old_sample = s1_stale_q ? '0 : ram_rdata;
      diff_ext   = (ACC_BITS + 1)'(s2_diff_q);
      acc_sum    = $signed({1'b0, acc_q}) + diff_ext;
      acc_rnd    = '0;

      // Stage 1: capture the accepted sample, advance pointer and counters
      if (ENABLE) begin
         wr_ptr_d   = wr_ptr_q + LOG2_WINDOW'(1);
         if (fill_cnt_q != FILL_FULL) begin
            fill_cnt_d = fill_cnt_q + FILL_W'(1);
         end
         filled_d   = (fill_cnt_d == FILL_FULL);
         dcnt_d     = dcnt_wrap ? '0 : dcnt_q + DCNT_BITS'(1);
         s1_vld_d   = 1'b1;
         s1_x_d     = DATA_IN;
         // Slot never written since reset: evicted value counts as zero
         s1_stale_d = (fill_cnt_q != FILL_FULL);
         // Emit only if this wrap also completes (or follows) the first fill
         s1_qual_d  = dcnt_wrap && (fill_cnt_q >= FILL_LAST);
      end

      // Stage 2: difference between entering and evicted samples
      if (s1_vld_q) begin
         s2_diff_d = $signed({1'b0, s1_x_q}) - $signed({1'b0, old_sample});
         s2_qual_d = s1_qual_q;
      end

      // Stage 3/4: update running sum, publish the mean on qualifying samples
      if (s2_vld_q) begin
         acc_d = ACC_BITS'(acc_sum);
`ifdef BOXCAR_ROUND_EN
         acc_rnd = acc_d + ROUND_HALF;
`else
         acc_rnd = acc_d;
`endif
         if (s2_qual_q) begin
            data_out_d = DATA_W'(acc_rnd >> LOG2_WINDOW);
            trigger_d  = 1'b1;
         end
      end
   end

   // State and pipeline registers with synchronous reset
   always_ff @(posedge CLOCK_IN) begin
      if (RESET_IN) begin
         wr_ptr_q   <= '0;
         fill_cnt_q <= '0;
         filled_q   <= 1'b0;
         dcnt_q     <= '0;
         s1_vld_q   <= 1'b0;
         s1_x_q     <= '0;
         s1_stale_q <= 1'b0;
         s1_qual_q  <= 1'b0;
         s2_vld_q   <= 1'b0;
         s2_diff_q  <= '0;
         s2_qual_q  <= 1'b0;
         acc_q      <= '0;
         data_out_q <= '0;
         trigger_q  <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         fill_cnt_q <= fill_cnt_d;
         filled_q   <= filled_d;
         dcnt_q     <= dcnt_d;
         s1_vld_q   <= s1_vld_d;
         s1_x_q     <= s1_x_d;
         s1_stale_q <= s1_stale_d;
         s1_qual_q  <= s1_qual_d;
         s2_vld_q   <= s2_vld_d;
         s2_diff_q  <= s2_diff_d;
         s2_qual_q  <= s2_qual_d;
         acc_q      <= acc_d;
         data_out_q <= data_out_d;
         trigger_q  <= trigger_d;
      end
   end

   assign DATA_OUT = data_out_q;
   assign TRIGGER  = trigger_q;
   assign FILLED   = filled_q;

endmodule : boxcar_decimator

// File: doc/boxcar_decimator.md
Name: boxcar_decimator

Overview:
- Parametrised moving-average (boxcar) filter with integrated decimation for the ADC capture path.
- Accepts qualified samples at the ADC clock rate (65 MHz), keeps a running sum over a power-of-two window held in a ring buffer, and emits the window mean once every DECIM accepted samples.
- Emits a one-cycle TRIGGER strobe with each output; downstream logic consumes DATA_OUT on that strobe.

Parameters:
- DATA_W, 14, sample and output width in bits; samples are unsigned (offset binary).
- LOG2_WINDOW, 8, window length N = 2**LOG2_WINDOW samples; legal range 1..12.
- DECIM, 325, accepted samples per output (65 MHz / 200 kHz); legal range 1..65535.

Ports:
- CLOCK_IN  in  1  sole clock; all logic on its rising edge.
- RESET_IN  in  1  synchronous, active-high reset.
- ENABLE  in  1  DATA_IN is a valid sample this cycle.
- DATA_IN  in  DATA_W  unsigned input sample.
- DATA_OUT  out  DATA_W  window mean; held between strobes.
- TRIGGER  out  1  one-cycle pulse: new DATA_OUT valid this cycle.
- FILLED  out  1  high once N samples have been accepted since reset.

Behaviour:
- Reset: the clock is CLOCK_IN; reset is synchronous and active-high on RESET_IN.
  - Reset values: DATA_OUT=0, TRIGGER=0, FILLED=0.
  - Reset also clears the write pointer, fill counter, decimation counter, accumulator and all pipeline valids.
  - RAM contents are not reset.
- Accept: a sample is accepted on any cycle with ENABLE=1 and RESET_IN=0. With ENABLE=0 nothing advances and all state holds.
- Stage 1 (accept cycle):
  - Read ring slot [wr_ptr], which holds x[n-N].
  - Register x[n] and write it to [wr_ptr]. Read-during-write must return old data.
  - wr_ptr increments and wraps naturally at N.
- Stage 2: diff = x[n] - old. old is forced to 0 while fill count < N, since pre-fill slots are stale.
  - diff is signed, DATA_W+1 bits.
- Stage 3: acc <= acc + diff.
  - acc is unsigned, ACC_W = DATA_W+LOG2_WINDOW bits, and never overflows.
- Stage 4: DATA_OUT <= acc >> LOG2_WINDOW (truncated); TRIGGER <= 1.
  - Latency: TRIGGER is high exactly 3 cycles after the accept cycle of the qualifying sample.
  - Stages 2-4 advance on their own valid bits, independent of ENABLE, so the pipeline drains during gaps.
- Fill counter: saturates at N. FILLED goes high in the cycle after the N-th accept and stays high until reset.
- Decimation counter: runs 0..DECIM-1 on accepted samples from reset, whether or not FILLED is high.
  - A sample is qualifying when the counter wraps (DECIM-1 -> 0) and the window is full including that sample.
  - Wraps before the window is full are silently dropped; the counter still wraps.
  - DECIM=1: every accepted sample after fill qualifies.
- Back-to-back: TRIGGER may be high on consecutive cycles when DECIM=1 and ENABLE=1 continuously.
- Reset mid-operation: in-flight pipeline entries are discarded; no TRIGGER is emitted in the cycles after reset until a fresh fill completes.
- Window wrap: after fill, the oldest sample is subtracted exactly once per accept.
  - Required invariant: acc = sum of the last N accepted samples.

Optional Feature:
- BOXCAR_ROUND_EN defined: DATA_OUT = (acc + 2**(LOG2_WINDOW-1)) >> LOG2_WINDOW, i.e. round half up.
  - No saturation is needed: the maximum result is 2**DATA_W-1.
  - The adder is ACC_W bits wide.
- BOXCAR_ROUND_EN undefined: plain truncation as above.
- Latency is identical in both builds.

Decomposition:
- Package boxcar_pkg holds:
  - localparam functions ACC_W(DATA_W, LOG2_WINDOW) and DCNT_W(DECIM) = $clog2(DECIM+1);
  - the legal-range constants for parameter checks;
  - an elaboration-time assertion that LOG2_WINDOW and DECIM are in range.
- One sub-module, boxcar_ring_ram: simple dual-port, depth 2**LOG2_WINDOW, width DATA_W, same-address read-during-write returning old data, no reset.
  - Inferred as block RAM.
  - The top holds the pointers, counters, pipeline and output registers.

Test Plan:
- LOG2_WINDOW=3, DECIM=4, constant DATA_IN=1000, ENABLE=1 from reset:
  - FILLED rises after the 8th accept;
  - the wrap at accept 4 emits no TRIGGER;
  - first TRIGGER 3 cycles after accept 8, DATA_OUT=1000;
  - thereafter TRIGGER every 4 cycles, DATA_OUT=1000.
- Same configuration, 16 samples of 0, then a step to 800:
  - successive outputs are 0, 400, 800.
  - Checks subtraction of the evicted sample at the window wrap.
- ENABLE toggled randomly at 30% duty, random data:
  - TRIGGER count equals floor(accepts/DECIM) minus suppressed pre-fill wraps;
  - each DATA_OUT equals the reference mean of the last 8 accepted samples;
  - no output change while ENABLE=0 beyond pipeline drain.
- Rounding, LOG2_WINDOW=2, window {1,1,1,2} (sum 5):
  - truncation build gives DATA_OUT=1; BOXCAR_ROUND_EN build gives DATA_OUT=1.
  - Window {1,1,2,2} (sum 6): truncation gives 1, rounding gives 2.
- Full scale, DATA_W=14, all samples 16383, LOG2_WINDOW=12:
  - DATA_OUT=16383 in both builds, no wrap.
- RESET_IN pulsed 1 cycle while 2 samples are in flight, then refill with 500:
  - no TRIGGER until a new fill completes;
  - first output is 500; FILLED low during refill.
